sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial pattern transmitter that emits a programmable bit pattern, MSB first, one bit per clock. It is the transmit end of our serial sequence-detection path, and its x_out drives a detector's serial x input. Supports repeated frames, an idle gap between frames, abort, and a one-cycle done pulse.

Parameters:
PAT_W, 5, pattern length in bits (>=2)
DEF_PATTERN, 5'b10110, pattern register value after reset (PAT_W bits wide)
GAP_W, 4, width of the inter-frame gap counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  begin transmission; sampled only in IDLE
abort  input  1  stop transmission; sampled in SHIFT/GAP
load_pattern  input  1  capture pattern_in into pattern register; sampled only in IDLE
pattern_in  input  PAT_W  new pattern, MSB transmitted first
repeat_cnt  input  4  extra frames; frames sent = repeat_cnt+1; latched on start
gap_len  input  GAP_W  idle cycles between frames; latched on start
x_out  output  1  serial data bit
x_valid  output  1  x_out carries a pattern bit this cycle
busy  output  1  transmission in progress
done  output  1  one-cycle pulse after the final bit

Behaviour:
- All outputs are registered. On reset assertion the block goes immediately to IDLE and sets pattern=DEF_PATTERN, x_out=0, x_valid=0, busy=0, done=0, and clears the bit, frame and gap counters.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - load_pattern=1 at an edge latches pattern_in.
  - start=1 at edge k latches repeat_cnt and gap_len, and moves to SHIFT.
  - At edge k: x_out<=pattern[PAT_W-1], x_valid<=1, busy<=1. Latency from start to first bit is 1 edge.
  - If start and load_pattern are both high at the same edge, the load takes effect first and the new pattern is transmitted.
- SHIFT:
  - One bit per cycle, MSB first; x_valid=1 for exactly PAT_W cycles per frame.
  - After the last bit with frames remaining and gap_len>0: go to GAP.
  - After the last bit with frames remaining and gap_len=0: start the next frame back-to-back with no x_valid dropout.
  - After the last bit with no frames remaining: go to DONE.
- GAP: x_out=0, x_valid=0, busy=1 for exactly gap_len cycles, then SHIFT restarts from the MSB.
- DONE: done=1, busy=0, x_valid=0 for one cycle, then IDLE.
- Total cycles from start to done: (R+1)*PAT_W + R*G, where R=repeat_cnt and G=gap_len. done is asserted in the following cycle.
- start, load_pattern, repeat_cnt and gap_len changes while busy=1 are ignored. The pattern register is never modified mid-transmission.
- abort=1 in SHIFT or GAP: at the next edge go to IDLE with x_valid=0, x_out=0, busy=0. No done pulse. abort in IDLE or DONE has no effect.
- Reset mid-frame: immediate return to reset values; the pattern register reverts to DEF_PATTERN.
- The frame counter counts down from repeat_cnt. repeat_cnt=15 yields 16 frames; the counter has no wrap issue.

Optional Feature:
SEQGEN_PARITY_EN
- Defined: after the PAT_W data bits of each frame, one extra bit is sent equal to the even parity (XOR) of the pattern, with x_valid=1. Frame length becomes PAT_W+1 and the total cycle formula uses PAT_W+1.
- Undefined: no parity bit; frame length is PAT_W and no parity logic is present.

Test Plan:
1. reset, then start with repeat_cnt=0 and gap_len=0 -> x_out=1,0,1,1,0 with x_valid high for 5 cycles; done pulses at cycle 6; busy high during cycles 1-5.
2. load_pattern with pattern_in=5'b01101, then start with repeat_cnt=2 and gap_len=3 -> three frames of 0,1,1,0,1, each separated by 3 cycles of x_valid=0; done after 21 cycles.
3. repeat_cnt=1, gap_len=0 -> 10 consecutive valid bits 1011010110 with no dropout, then done.
4. abort asserted on the 3rd bit of a frame -> x_valid=0 and busy=0 at the next edge, done never asserted; a following start transmits normally.
5. start and load_pattern (pattern_in=5'b11100) pulsed while busy -> ignored, current frames unchanged. Asynchronous reset mid-GAP -> outputs 0 immediately and pattern back to 10110.
6. With SEQGEN_PARITY_EN defined and pattern 10110 -> bits 1,0,1,1,0,1 (parity=1); done after 6 cycles.

Source files
------------

// File: rtl/sequence_generator_if.sv
// Control and serial-output bundle for sequence_generator.
// The master drives the controls; the slave returns the serial stream and status.
interface sequence_generator_if #(
    parameter int PAT_W = 5,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic             load_pattern;
    logic [PAT_W-1:0] pattern_in;
    logic [3:0]       repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, load_pattern, pattern_in, repeat_cnt, gap_len,
        input  x_out, x_valid, busy, done
    );

    modport slave (
        input  start, abort, load_pattern, pattern_in, repeat_cnt, gap_len,
        output x_out, x_valid, busy, done
    );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: MSB-first frames with repeat, idle gap, abort and done pulse.
// Optional SEQGEN_PARITY_EN appends an even-parity bit to every frame.
module sequence_generator #(
    parameter int               PAT_W       = 5,
    parameter logic [PAT_W-1:0] DEF_PATTERN = 5'b10110,
    parameter int               GAP_W       = 4
) (
    input logic               clk,
    input logic               reset,
    sequence_generator_if.slave bus
);

`ifdef SEQGEN_PARITY_EN
    localparam int FRAME_W = PAT_W + 1;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [PAT_W-1:0] pat);
        return {pat, ^pat};
    endfunction
`else
    localparam int FRAME_W = PAT_W;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [PAT_W-1:0] pat);
        return pat;
    endfunction
`endif

    localparam int               BIT_W    = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t             state;
    logic [PAT_W-1:0]   pattern;
    logic [FRAME_W-1:0] shreg;
    logic [BIT_W-1:0]   bit_pos;
    logic [3:0]         frame_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_len_r;
    logic [FRAME_W-1:0] frame_start;
    logic [FRAME_W-1:0] frame_cur;

    // A same-edge load wins, so the first frame is built from pattern_in.
    always_comb begin
        frame_start = build_frame(bus.load_pattern ? bus.pattern_in : pattern);
        frame_cur   = build_frame(pattern);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pattern     <= DEF_PATTERN;
            shreg       <= '0;
            bit_pos     <= '0;
            frame_cnt   <= '0;
            gap_cnt     <= '0;
            gap_len_r   <= '0;
            bus.x_out   <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else if ((state == SHIFT || state == GAP) && bus.abort) begin
            state       <= IDLE;
            bus.x_out   <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_pattern) pattern <= bus.pattern_in;
                    if (bus.start) begin
                        frame_cnt   <= bus.repeat_cnt;
                        gap_len_r   <= bus.gap_len;
                        bit_pos     <= '0;
                        bus.x_out   <= frame_start[FRAME_W-1];
                        shreg       <= frame_start << 1;
                        bus.x_valid <= 1'b1;
                        bus.busy    <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_pos != LAST_BIT) begin
                        bit_pos   <= bit_pos + BIT_W'(1);
                        bus.x_out <= shreg[FRAME_W-1];
                        shreg     <= shreg << 1;
                    end else if (frame_cnt != 4'd0) begin
                        frame_cnt <= frame_cnt - 4'd1;
                        if (gap_len_r != '0) begin
                            gap_cnt     <= gap_len_r;
                            bus.x_out   <= 1'b0;
                            bus.x_valid <= 1'b0;
                            state       <= GAP;
                        end else begin
                            bit_pos   <= '0;
                            bus.x_out <= frame_cur[FRAME_W-1];
                            shreg     <= frame_cur << 1;
                        end
                    end else begin
                        bus.x_out   <= 1'b0;
                        bus.x_valid <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        state       <= DONE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        bit_pos     <= '0;
                        bus.x_out   <= frame_cur[FRAME_W-1];
                        shreg       <= frame_cur << 1;
                        bus.x_valid <= 1'b1;
                        state       <= SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: expected {x_valid,x_out,busy,done} per cycle
// is queued when a transmission is launched and compared cycle by cycle.
module tb_sequence_generator;

    localparam int PAT_W = 5;
    localparam int GAP_W = 4;
`ifdef SEQGEN_PARITY_EN
    localparam int FRAME_W = PAT_W + 1;
`else
    localparam int FRAME_W = PAT_W;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sequence_generator_if #(.PAT_W(PAT_W), .GAP_W(GAP_W)) bus ();

    sequence_generator #(
        .PAT_W(PAT_W),
        .DEF_PATTERN(5'b10110),
        .GAP_W(GAP_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int tests  = 0;
    int failed = 0;
    logic [PAT_W-1:0] model_pattern;
    logic [3:0] exp_q[$];

    function automatic logic [3:0] observed();
        return {bus.x_valid, bus.x_out, bus.busy, bus.done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Builds the cycle-accurate expectation of one transmission from the bench's own pattern copy.
    task automatic push_frames(input int r, input int g);
        logic bit_v;
        for (int f = 0; f <= r; f++) begin
            for (int b = 0; b < FRAME_W; b++) begin
                bit_v = (b < PAT_W) ? model_pattern[PAT_W-1-b] : ^model_pattern;
                exp_q.push_back({1'b1, bit_v, 1'b1, 1'b0});
            end
            if (f < r)
                for (int k = 0; k < g; k++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
    endtask

    task automatic drain(input string name, input int poke_at, input int stop_at);
        logic [3:0] exp;
        int c = 0;
        while (exp_q.size() > 0 && c != stop_at) begin
            exp = exp_q.pop_front();
            check($sformatf("%s cyc%0d", name, c + 1), 32'(observed()), 32'(exp));
            if (c == poke_at) begin
                bus.start        = 1'b1;
                bus.load_pattern = 1'b1;
                bus.pattern_in   = 5'b11100;
                bus.repeat_cnt   = 4'd7;
                bus.gap_len      = '0;
            end
            if (c == poke_at + 1) begin
                bus.start        = 1'b0;
                bus.load_pattern = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        bus.start        = 1'b0;
        bus.load_pattern = 1'b0;
    endtask

    task automatic start_tx(input string name, input int r, input int g,
                            input int poke_at, input int stop_at);
        push_frames(r, g);
        bus.repeat_cnt = 4'(r);
        bus.gap_len    = GAP_W'(g);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain(name, poke_at, stop_at);
    endtask

    task automatic load(input logic [PAT_W-1:0] pat);
        bus.pattern_in   = pat;
        bus.load_pattern = 1'b1;
        @(negedge clk);
        bus.load_pattern = 1'b0;
        model_pattern    = pat;
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.load_pattern = 1'b0;
        bus.pattern_in   = '0;
        bus.repeat_cnt   = '0;
        bus.gap_len      = '0;
        model_pattern    = 5'b10110;
        repeat (2) @(negedge clk);
        check("reset outputs", 32'(observed()), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle outputs", 32'(observed()), 32'h0);

        start_tx("single", 0, 0, -1, -1);

        load(5'b01101);
        start_tx("gap3x3", 2, 3, -1, -1);

        load(5'b10110);
        start_tx("b2b", 1, 0, -1, -1);

        // Abort while the third bit is on the line.
        bus.repeat_cnt = 4'd0;
        bus.gap_len    = '0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check($sformatf("abort bit%0d", b), 32'(observed()),
                  32'({1'b1, model_pattern[PAT_W-1-b], 1'b1, 1'b0}));
            if (b == 2) bus.abort = 1'b1;
            @(negedge clk);
        end
        bus.abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post abort %0d", k), 32'(observed()), 32'h0);
            @(negedge clk);
        end
        start_tx("after abort", 0, 0, -1, -1);

        start_tx("busy ignore", 1, 3, 1, -1);

        // Stop on the second gap cycle and hit the asynchronous reset.
        start_tx("pre reset", 2, 3, -1, FRAME_W + 1);
        exp_q.delete();
        check("gap before reset", 32'(observed()), 32'h2);
        reset = 1'b1;
        #1;
        check("async reset", 32'(observed()), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_pattern = 5'b10110;
        start_tx("default pattern", 0, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
